game_sequencer: RTL and testbench

Top-level flow controller for the shooter game engine. It sequences the game through idle, countdown, play, pause and game-over phases. It generates the enemy move and spawn timing pulses, picks which free enemy slot receives the next spawn, and clears and enables the engine datapath. The engine consumes move_tick, spawn_tick/spawn_slot, engine_run and engine_clear in place of its own free-running counters.

---
 rtl/game_pkg.sv | 24 ++
 rtl/game_sequencer_if.sv | 29 ++
 rtl/period_timer.sv | 42 ++++
 rtl/game_sequencer.sv | 179 +++++++++++++++++
 tb/tb_game_sequencer.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the game flow controller: phase encodings, default
// timing dividers and enemy slot geometry.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        COUNTDOWN = 3'd1,
        PLAY      = 3'd2,
        PAUSE     = 3'd3,
        OVER      = 3'd4
    } game_state_t;

    localparam int unsigned END_SCORE_DEF    = 20;
    localparam int unsigned MOVE_DIV_DEF     = 200_000_000;
    localparam int unsigned SLOW_GEN_DIV_DEF = 200_000_000;
    localparam int unsigned FAST_GEN_DIV_DEF = 100_000_000;
    localparam int unsigned COUNT_DIV_DEF    = 100_000_000;
    localparam int unsigned CNT_W_DEF        = 28;

    localparam int NUM_SLOTS = 8;
    localparam int SLOT_W    = 3;
    localparam int SCORE_W   = 5;

endpackage

// File: rtl/game_sequencer_if.sv
// Engine-facing bundle of the game sequencer.
//   occupancy, score, breach : engine status into the sequencer
//   engine_run, engine_clear : datapath enable / one-cycle clear
//   move_tick                : advance all live enemies one ring
//   spawn_tick, spawn_slot   : spawn one enemy into spawn_slot
// master = sequencer side, slave = engine side.
interface game_sequencer_if;
    import game_pkg::*;

    logic [NUM_SLOTS-1:0] occupancy;
    logic [SCORE_W-1:0]   score;
    logic                 breach;
    logic                 engine_run;
    logic                 engine_clear;
    logic                 move_tick;
    logic                 spawn_tick;
    logic [SLOT_W-1:0]    spawn_slot;

    modport master (
        input  occupancy, score, breach,
        output engine_run, engine_clear, move_tick, spawn_tick, spawn_slot
    );

    modport slave (
        output occupancy, score, breach,
        input  engine_run, engine_clear, move_tick, spawn_tick, spawn_slot
    );

endinterface

// File: rtl/period_timer.sv
// Free-running period counter: counts 0..period-1 and wraps.
//   clk, reset : clock, asynchronous active-low reset
//   en         : count enable; holding en low freezes the count (incl. at terminal)
//   clr        : synchronous clear to 0, overrides en
//   period     : cycles per period, sampled every cycle
//   terminal   : count >= period-1 (>= so a shortened period never overshoots)
//   count      : current count
module period_timer #(
    parameter int unsigned WIDTH = 28
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] period,
    output logic             terminal,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q, count_d;

    assign terminal = (count_q >= period - WIDTH'(1));
    assign count    = count_q;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = terminal ? '0 : count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/game_sequencer.sv
// Top-level flow controller of the shooter engine: IDLE -> COUNTDOWN -> PLAY
// <-> PAUSE -> OVER, with enemy move/spawn pacing and round-robin spawn slot pick.
//   clk, reset        : clock, asynchronous active-low reset
//   start_btn         : synchronized start level; rising edge starts a game
//   pause_sw, fast_sw : pause request, fast spawn period select
//   eng               : engine bundle (master side)
//   state             : current phase
//   countdown         : digit 3,2,1 during COUNTDOWN, else 0
//   final_score       : score latched on entry to OVER
//   game_over         : high in OVER
module game_sequencer
    import game_pkg::*;
#(
    parameter int unsigned END_SCORE    = END_SCORE_DEF,
    parameter int unsigned MOVE_DIV     = MOVE_DIV_DEF,
    parameter int unsigned SLOW_GEN_DIV = SLOW_GEN_DIV_DEF,
    parameter int unsigned FAST_GEN_DIV = FAST_GEN_DIV_DEF,
    parameter int unsigned COUNT_DIV    = COUNT_DIV_DEF,
    parameter int unsigned CNT_W        = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_btn,
    input  logic                 pause_sw,
    input  logic                 fast_sw,
    game_sequencer_if.master     eng,
    output logic [2:0]           state,
    output logic [1:0]           countdown,
    output logic [SCORE_W-1:0]   final_score,
    output logic                 game_over
);

    localparam logic [SCORE_W-1:0] END_SCORE_V = SCORE_W'(END_SCORE);

    game_state_t         state_q, state_d;
    logic                start_prev_q;
    logic [1:0]          countdown_q, countdown_d;
    logic [SCORE_W-1:0]  final_score_q, final_score_d;
    logic                engine_clear_q, engine_clear_d;
    logic                move_tick_q, move_tick_d;
    logic [SLOT_W-1:0]   rr_ptr_q, rr_ptr_d;

    logic                start_edge, start_go, cd_done, game_end;
    logic                play_stay, slots_full, spawn;
    logic                cd_term, move_term, gen_term;
    logic [CNT_W-1:0]    cd_cnt, move_cnt, gen_cnt, gen_period;
    logic [SLOT_W-1:0]   pick_slot;
    logic                pick_found;

    assign start_edge = start_btn & ~start_prev_q;
    assign game_end   = eng.breach | (eng.score >= END_SCORE_V);
    assign slots_full = &eng.occupancy;
    assign gen_period = fast_sw ? CNT_W'(FAST_GEN_DIV) : CNT_W'(SLOW_GEN_DIV);

    always_comb begin
        state_d        = state_q;
        countdown_d    = countdown_q;
        final_score_d  = final_score_q;
        engine_clear_d = 1'b0;
        start_go       = 1'b0;
        cd_done        = 1'b0;
        case (state_q)
            IDLE:      start_go = start_edge;
            COUNTDOWN: begin
                if (cd_term) begin
                    if (countdown_q > 2'd1) begin
                        countdown_d = countdown_q - 2'd1;
                    end else begin
                        state_d     = PLAY;
                        countdown_d = 2'd0;
                        cd_done     = 1'b1;
                    end
                end
            end
            PLAY: begin
                if (game_end) begin
                    state_d       = OVER;
                    final_score_d = eng.score;
                end else if (pause_sw) begin
                    state_d = PAUSE;
                end
            end
            PAUSE:     if (!pause_sw) state_d = PLAY;
            OVER:      start_go = start_edge;
            default:   state_d = IDLE;
        endcase
        if (start_go) begin
            state_d        = COUNTDOWN;
            countdown_d    = 2'd3;
            final_score_d  = '0;
            engine_clear_d = 1'b1;
        end
    end

    // Timers only run while PLAY continues into the next cycle, so a tick that
    // falls on the exit cycle stays pending and fires once play resumes.
    assign play_stay   = (state_q == PLAY) && (state_d == PLAY);
    assign spawn       = play_stay & gen_term & ~slots_full;
    assign move_tick_d = play_stay & move_term;

    // First free slot scanning upward from rr_ptr, wrapping mod NUM_SLOTS.
    always_comb begin
        pick_slot  = rr_ptr_q;
        pick_found = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!pick_found && !eng.occupancy[rr_ptr_q + SLOT_W'(i)]) begin
                pick_found = 1'b1;
                pick_slot  = rr_ptr_q + SLOT_W'(i);
            end
        end
    end

    assign rr_ptr_d = spawn ? pick_slot + SLOT_W'(1) : rr_ptr_q;

    period_timer #(.WIDTH(CNT_W)) u_cd_timer (
        .clk      (clk),
        .reset    (reset),
        .en       (state_q == COUNTDOWN),
        .clr      (start_go),
        .period   (CNT_W'(COUNT_DIV)),
        .terminal (cd_term),
        .count    (cd_cnt)
    );

    period_timer #(.WIDTH(CNT_W)) u_move_timer (
        .clk      (clk),
        .reset    (reset),
        .en       (play_stay),
        .clr      (cd_done),
        .period   (CNT_W'(MOVE_DIV)),
        .terminal (move_term),
        .count    (move_cnt)
    );

    // Holds at terminal while every slot is occupied: the spawn stays pending.
    period_timer #(.WIDTH(CNT_W)) u_gen_timer (
        .clk      (clk),
        .reset    (reset),
        .en       (play_stay & ~(gen_term & slots_full)),
        .clr      (cd_done),
        .period   (gen_period),
        .terminal (gen_term),
        .count    (gen_cnt)
    );

    logic unused_cnt;
    assign unused_cnt = ^{cd_cnt, move_cnt, gen_cnt};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            start_prev_q   <= 1'b1;
            countdown_q    <= 2'd0;
            final_score_q  <= '0;
            engine_clear_q <= 1'b0;
            move_tick_q    <= 1'b0;
            rr_ptr_q       <= '0;
        end else begin
            state_q        <= state_d;
            start_prev_q   <= start_btn;
            countdown_q    <= countdown_d;
            final_score_q  <= final_score_d;
            engine_clear_q <= engine_clear_d;
            move_tick_q    <= move_tick_d;
            rr_ptr_q       <= rr_ptr_d;
        end
    end

    assign state            = state_q;
    assign countdown        = countdown_q;
    assign final_score      = final_score_q;
    assign game_over        = (state_q == OVER);
    assign eng.engine_run   = (state_q == PLAY);
    assign eng.engine_clear = engine_clear_q;
    assign eng.move_tick    = move_tick_q;
    assign eng.spawn_tick   = spawn;
    assign eng.spawn_slot   = spawn ? pick_slot : '0;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with small dividers; spawn slots are
// checked against a queue of expected slots filled as stimulus is applied.
module tb_game_sequencer;

    logic       clk;
    logic       reset;
    logic       start_btn;
    logic       pause_sw;
    logic       fast_sw;
    logic [2:0] state;
    logic [1:0] countdown;
    logic [4:0] final_score;
    logic       game_over;

    int n_cmp = 0;
    int n_bad = 0;
    logic [2:0] exp_q[$];

    game_sequencer_if eng ();

    game_sequencer #(
        .END_SCORE    (20),
        .MOVE_DIV     (8),
        .SLOW_GEN_DIV (12),
        .FAST_GEN_DIV (6),
        .COUNT_DIV    (4),
        .CNT_W        (28)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start_btn   (start_btn),
        .pause_sw    (pause_sw),
        .fast_sw     (fast_sw),
        .eng         (eng.master),
        .state       (state),
        .countdown   (countdown),
        .final_score (final_score),
        .game_over   (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_state"}, 32'(state), 0);
        check({tag, "_run"}, 32'(eng.engine_run), 0);
        check({tag, "_clear"}, 32'(eng.engine_clear), 0);
        check({tag, "_move"}, 32'(eng.move_tick), 0);
        check({tag, "_spawn"}, 32'(eng.spawn_tick), 0);
        check({tag, "_slot"}, 32'(eng.spawn_slot), 0);
        check({tag, "_cd"}, 32'(countdown), 0);
        check({tag, "_final"}, 32'(final_score), 0);
        check({tag, "_over"}, 32'(game_over), 0);
    endtask

    // Every spawn the DUT produces must match the next expected slot.
    always @(negedge clk) begin
        if (eng.spawn_tick === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $error("FAIL unexpected_spawn: observed slot %0d expected no spawn",
                       eng.spawn_slot);
            end else begin
                check("spawn_slot", 32'(eng.spawn_slot), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        reset         = 1'b1;
        start_btn     = 1'b1;
        pause_sw      = 1'b0;
        fast_sw       = 1'b0;
        eng.occupancy = 8'h00;
        eng.score     = 5'd0;
        eng.breach    = 1'b0;
        #2 reset = 1'b0;
        #1 check_all_zero("reset");

        // Button held through reset release must not start a game.
        cyc(2);
        reset = 1'b1;
        cyc(3);
        check("held_btn_idle", 32'(state), 0);
        check("held_btn_clear", 32'(eng.engine_clear), 0);
        start_btn = 1'b0;
        cyc(1);
        start_btn = 1'b1;

        // Countdown: 3,2,1 each for 4 cycles.
        cyc(1);
        check("start_state", 32'(state), 1);
        check("start_clear", 32'(eng.engine_clear), 1);
        check("start_cd", 32'(countdown), 3);
        cyc(1);
        check("clear_one_cycle", 32'(eng.engine_clear), 0);
        cyc(2);
        check("cd3_last", 32'(countdown), 3);
        cyc(1);
        check("cd2_first", 32'(countdown), 2);
        cyc(3);
        check("cd2_last", 32'(countdown), 2);
        cyc(1);
        check("cd1_first", 32'(countdown), 1);
        cyc(3);
        check("cd1_last_state", 32'(state), 1);
        cyc(1);
        // P0: play begins
        check("play_state", 32'(state), 2);
        check("play_run", 32'(eng.engine_run), 1);
        check("play_cd", 32'(countdown), 0);
        exp_q.push_back(3'd0);
        cyc(7);
        check("move_p7", 32'(eng.move_tick), 0);
        cyc(1);
        check("move_p8", 32'(eng.move_tick), 1);
        cyc(1);
        check("move_p9", 32'(eng.move_tick), 0);
        cyc(2);
        check("spawn_p11", 32'(eng.spawn_tick), 1);

        // Slots 1,2 occupied with rr_ptr=1 -> slot 3.
        cyc(1);
        eng.occupancy = 8'b0000_0110;
        exp_q.push_back(3'd3);
        cyc(10);
        check("spawn_p22", 32'(eng.spawn_tick), 0);
        cyc(1);
        check("spawn_p23", 32'(eng.spawn_tick), 1);
        cyc(1);
        check("move_p24", 32'(eng.move_tick), 1);
        eng.occupancy = 8'h00;
        exp_q.push_back(3'd4);
        cyc(11);
        check("spawn_p35", 32'(eng.spawn_tick), 1);

        // All slots full: spawn stays pending until slot 5 frees.
        cyc(1);
        eng.occupancy = 8'hFF;
        cyc(11);
        check("full_p47", 32'(eng.spawn_tick), 0);
        cyc(20);
        check("full_p67", 32'(eng.spawn_tick), 0);
        eng.occupancy = 8'hDF;
        fast_sw = 1'b1;
        exp_q.push_back(3'd5);
        #1 check("freed_spawn", 32'(eng.spawn_tick), 1);
        cyc(1);
        eng.occupancy = 8'h00;
        exp_q.push_back(3'd6);
        check("after_freed_p68", 32'(eng.spawn_tick), 0);
        cyc(4);
        check("fast_p72", 32'(eng.spawn_tick), 0);
        cyc(1);
        check("fast_p73", 32'(eng.spawn_tick), 1);
        exp_q.push_back(3'd7);
        cyc(6);
        check("fast_p79", 32'(eng.spawn_tick), 1);
        cyc(1);
        fast_sw = 1'b0;

        // Pause at move count 5 for 30 cycles.
        cyc(5);
        pause_sw = 1'b1;
        cyc(1);
        check("pause_state", 32'(state), 3);
        check("pause_run", 32'(eng.engine_run), 0);
        cyc(2);
        check("pause_no_move", 32'(eng.move_tick), 0);
        cyc(27);
        check("pause_still", 32'(state), 3);
        check("pause_no_spawn", 32'(eng.spawn_tick), 0);
        pause_sw = 1'b0;
        cyc(1);
        check("resume_state", 32'(state), 2);
        exp_q.push_back(3'd0);
        cyc(2);
        check("resume_move_r2", 32'(eng.move_tick), 0);
        cyc(1);
        check("resume_move_r3", 32'(eng.move_tick), 1);
        cyc(3);
        check("resume_spawn", 32'(eng.spawn_tick), 1);

        // Win and breach together -> OVER with score latched.
        cyc(3);
        eng.score  = 5'd20;
        eng.breach = 1'b1;
        cyc(1);
        check("over_state", 32'(state), 4);
        check("over_flag", 32'(game_over), 1);
        check("over_final", 32'(final_score), 20);
        check("over_run", 32'(eng.engine_run), 0);
        eng.score  = 5'd3;
        eng.breach = 1'b0;
        cyc(5);
        check("over_held_state", 32'(state), 4);
        check("over_held_final", 32'(final_score), 20);
        start_btn = 1'b0;
        cyc(1);
        start_btn = 1'b1;
        cyc(1);
        check("restart_state", 32'(state), 1);
        check("restart_clear", 32'(eng.engine_clear), 1);
        check("restart_over", 32'(game_over), 0);
        check("restart_final", 32'(final_score), 0);
        check("restart_cd", 32'(countdown), 3);
        cyc(12);
        check("replay_state", 32'(state), 2);
        cyc(3);
        check("replay_run", 32'(eng.engine_run), 1);

        // Reset mid-play clears outputs without a clock edge.
        #3 reset = 1'b0;
        #1 check_all_zero("midreset");
        cyc(1);
        reset = 1'b1;
        cyc(2);
        check("post_reset_idle", 32'(state), 0);
        check("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
